// File: rtl/ysyx_23060251_axi_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_23060251_axi_arbiter_if
// Purpose  : AXI-Lite channel bundle (AR/R/AW/W/B) used on every side of the
//            2:1 arbiter. Each master port and the shared slave port is one
//            instance of this interface.
// Modports : master - drives AR/AW/W valid+payload and R/B ready
//            slave  - drives AR/AW/W ready and R/B valid+payload
// Params   : ADDR_W address width, DATA_W data width, STRB_W = DATA_W/8
// Resp     : 2-bit AXI response (OKAY/EXOKAY/SLVERR/DECERR)
// Revision : 1.0 - initial release
// ============================================================================
interface ysyx_23060251_axi_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  // read address
  logic              ar_valid;
  logic              ar_ready;
  logic [ADDR_W-1:0] ar_addr;
  // read data
  logic              r_valid;
  logic              r_ready;
  logic [DATA_W-1:0] r_data;
  logic [1:0]        r_resp;
  // write address
  logic              aw_valid;
  logic              aw_ready;
  logic [ADDR_W-1:0] aw_addr;
  // write data
  logic              w_valid;
  logic              w_ready;
  logic [DATA_W-1:0] w_data;
  logic [STRB_W-1:0] w_strb;
  // write response
  logic              b_valid;
  logic              b_ready;
  logic [1:0]        b_resp;

  modport master (
    output ar_valid, ar_addr,
    input  ar_ready,
    input  r_valid, r_data, r_resp,
    output r_ready,
    output aw_valid, aw_addr,
    input  aw_ready,
    output w_valid, w_data, w_strb,
    input  w_ready,
    input  b_valid, b_resp,
    output b_ready
  );

  modport slave (
    input  ar_valid, ar_addr,
    output ar_ready,
    output r_valid, r_data, r_resp,
    input  r_ready,
    input  aw_valid, aw_addr,
    output aw_ready,
    input  w_valid, w_data, w_strb,
    output w_ready,
    output b_valid, b_resp,
    input  b_ready
  );
endinterface
`default_nettype wire

// File: rtl/ysyx_23060251_axi_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_23060251_axi_arbiter
// Purpose  : 2:1 AXI-Lite arbiter sharing one memory slave between the IFU
//            (m0, read-only) and the LSU (m1, read + write). Exactly one
//            transaction is outstanding; the grant is held from the address
//            handshake until the response handshake.
// Ports    : clk_i  - clock, rising edge
//            rst_i  - synchronous reset, active high
//            m0     - IFU side (slave modport); its write channels are tied off
//            m1     - LSU side (slave modport)
//            s      - shared memory slave (master modport)
// Config   : YSYX_23060251_ARB_RR_EN
//              defined   - m0/m1 read ties resolved round-robin (m1 wins the
//                          first tie after reset); LSU write stays on top
//              undefined - fixed priority m1 write > m1 read > m0 read
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_23060251_axi_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  wire                         clk_i,
  input  wire                         rst_i,
  ysyx_23060251_axi_arbiter_if.slave  m0,
  ysyx_23060251_axi_arbiter_if.slave  m1,
  ysyx_23060251_axi_arbiter_if.master s
);

  localparam int STRB_W = DATA_W / 8;

  // One-hot grant state; the state register itself is the registered grant.
  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_RD_M0 = 4'b0010,
    S_RD_M1 = 4'b0100,
    S_WR_M1 = 4'b1000
  } state_t;

  state_t r_state;
  logic   r_ar_done;   // AR of the current read already accepted by the slave
  logic   r_aw_done;   // AW of the current write already accepted
  logic   r_w_done;    // W of the current write already accepted
`ifdef YSYX_23060251_ARB_RR_EN
  logic   r_last_m1;   // 1: last read grant went to m1
`endif

  state_t w_pick;
  logic   w_gnt_m0;
  logic   w_gnt_m1r;
  logic   w_gnt_wr;
  logic   w_gnt_rd;
  logic   w_ar_valid;
  logic   w_ar_hs;
  logic   w_r_route;
  logic   w_r_ready;
  logic   w_r_hs;
  logic   w_aw_valid;
  logic   w_w_valid;
  logic   w_aw_hs;
  logic   w_w_hs;
  logic   w_b_route;
  logic   w_b_ready;
  logic   w_b_hs;
  logic   w_unused;

  assign w_gnt_m0  = (r_state == S_RD_M0);
  assign w_gnt_m1r = (r_state == S_RD_M1);
  assign w_gnt_wr  = (r_state == S_WR_M1);
  assign w_gnt_rd  = w_gnt_m0 | w_gnt_m1r;

  // --------------------------------------------------------------------------
  // Arbitration, evaluated only while idle; the decision is registered so the
  // winner sees its path one cycle after presenting the request.
  // --------------------------------------------------------------------------
  always_comb begin
    w_pick = S_IDLE;
    if (m1.aw_valid) begin
      w_pick = S_WR_M1;
    end
`ifdef YSYX_23060251_ARB_RR_EN
    else if (m1.ar_valid && m0.ar_valid) begin
      w_pick = r_last_m1 ? S_RD_M0 : S_RD_M1;
    end
`endif
    else if (m1.ar_valid) begin
      w_pick = S_RD_M1;
    end
    else if (m0.ar_valid) begin
      w_pick = S_RD_M0;
    end
  end

  // --------------------------------------------------------------------------
  // Read path. Once AR has been accepted it is masked off, so a master that
  // keeps ar_valid high until its response never produces a second AR.
  // The R channel opens in the AR handshake cycle itself, allowing a slave
  // that answers combinationally to finish AR and R together.
  // --------------------------------------------------------------------------
  always_comb begin
    w_ar_valid = 1'b0;
    if (w_gnt_m0) begin
      w_ar_valid = m0.ar_valid;
    end else if (w_gnt_m1r) begin
      w_ar_valid = m1.ar_valid;
    end
  end

  assign s.ar_valid  = w_ar_valid & ~r_ar_done;
  assign s.ar_addr   = w_gnt_m0  ? m0.ar_addr :
                       w_gnt_m1r ? m1.ar_addr : '0;
  assign w_ar_hs     = s.ar_valid & s.ar_ready;

  assign m0.ar_ready = w_gnt_m0  & ~r_ar_done & s.ar_ready;
  assign m1.ar_ready = w_gnt_m1r & ~r_ar_done & s.ar_ready;

  assign w_r_route   = w_gnt_rd & (r_ar_done | w_ar_hs);
  assign w_r_ready   = w_gnt_m0 ? m0.r_ready : m1.r_ready;
  assign s.r_ready   = w_r_route & w_r_ready;
  assign w_r_hs      = s.r_valid & s.r_ready;

  assign m0.r_valid  = w_gnt_m0  & w_r_route & s.r_valid;
  assign m0.r_data   = w_gnt_m0  ? s.r_data : '0;
  assign m0.r_resp   = w_gnt_m0  ? s.r_resp : 2'b00;
  assign m1.r_valid  = w_gnt_m1r & w_r_route & s.r_valid;
  assign m1.r_data   = w_gnt_m1r ? s.r_data : '0;
  assign m1.r_resp   = w_gnt_m1r ? s.r_resp : 2'b00;

  // --------------------------------------------------------------------------
  // Write path (m1 only). AW and W complete independently in any order; each
  // is masked once accepted. B opens once both are in, or are completing in
  // this very cycle.
  // --------------------------------------------------------------------------
  assign w_aw_valid  = w_gnt_wr & m1.aw_valid & ~r_aw_done;
  assign w_w_valid   = w_gnt_wr & m1.w_valid  & ~r_w_done;

  assign s.aw_valid  = w_aw_valid;
  assign s.aw_addr   = w_gnt_wr ? m1.aw_addr : '0;
  assign s.w_valid   = w_w_valid;
  assign s.w_data    = w_gnt_wr ? m1.w_data : '0;
  assign s.w_strb    = w_gnt_wr ? m1.w_strb : {STRB_W{1'b0}};

  assign w_aw_hs     = w_aw_valid & s.aw_ready;
  assign w_w_hs      = w_w_valid  & s.w_ready;

  assign m1.aw_ready = w_gnt_wr & ~r_aw_done & s.aw_ready;
  assign m1.w_ready  = w_gnt_wr & ~r_w_done  & s.w_ready;

  assign w_b_route   = w_gnt_wr & (r_aw_done | w_aw_hs) & (r_w_done | w_w_hs);
  assign w_b_ready   = w_b_route & m1.b_ready;
  assign s.b_ready   = w_b_ready;
  assign w_b_hs      = s.b_valid & w_b_ready;

  assign m1.b_valid  = w_b_route & s.b_valid;
  assign m1.b_resp   = w_gnt_wr ? s.b_resp : 2'b00;

  // IFU never writes: its write channels are held quiet.
  assign m0.aw_ready = 1'b0;
  assign m0.w_ready  = 1'b0;
  assign m0.b_valid  = 1'b0;
  assign m0.b_resp   = 2'b00;

  assign w_unused    = ^{m0.aw_valid, m0.aw_addr, m0.w_valid, m0.w_data,
                         m0.w_strb, m0.b_ready};

  // --------------------------------------------------------------------------
  // Grant FSM. Reset drops any transaction in flight; the slave shares the
  // same reset so nothing is left dangling on its side.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_ar_done <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
`ifdef YSYX_23060251_ARB_RR_EN
      r_last_m1 <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state   <= w_pick;
          r_ar_done <= 1'b0;
          r_aw_done <= 1'b0;
          r_w_done  <= 1'b0;
`ifdef YSYX_23060251_ARB_RR_EN
          if (w_pick == S_RD_M0) begin
            r_last_m1 <= 1'b0;
          end else if (w_pick == S_RD_M1) begin
            r_last_m1 <= 1'b1;
          end
`endif
        end
        S_RD_M0, S_RD_M1: begin
          if (w_r_hs) begin
            r_state   <= S_IDLE;
            r_ar_done <= 1'b0;
          end else if (w_ar_hs) begin
            r_ar_done <= 1'b1;
          end
        end
        S_WR_M1: begin
          if (w_b_hs) begin
            r_state   <= S_IDLE;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
          end else begin
            if (w_aw_hs) begin
              r_aw_done <= 1'b1;
            end
            if (w_w_hs) begin
              r_w_done <= 1'b1;
            end
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_ar_done <= 1'b0;
          r_aw_done <= 1'b0;
          r_w_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
